// File: rtl/lut_seq_pkg.sv
// Shared types and defaults for the table-driven sequence controller.
package lut_seq_pkg;

  localparam int unsigned DEF_W  = 2;
  localparam int unsigned DEF_LW = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  // Default next-state for entry idx: a plain increment that wraps at 2**w.
  function automatic int unsigned default_next(input int unsigned idx, input int unsigned w);
    return (idx + 1) % (32'd1 << w);
  endfunction

endpackage

// File: rtl/lut_seq_table.sv
// Next-state lookup table: one write port, one combinational read port.
module lut_seq_table
  import lut_seq_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [W-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic [W-1:0] raddr,
  output logic [W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << W;

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[W'(i)] <= W'(default_next(i, W));
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lut_seq_ctrl.sv
// Run-length sequencer that steps count through a programmable next-state table.
module lut_seq_ctrl
  import lut_seq_pkg::*;
#(
  parameter int unsigned W  = DEF_W,
  parameter int unsigned LW = DEF_LW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [W-1:0]  cfg_addr,
  input  logic [W-1:0]  cfg_data,
  input  logic          start,
  input  logic [LW-1:0] run_len,
  input  logic          pause,
  input  logic          stop,
  input  logic          clr,
  output logic [W-1:0]  count,
  output logic          step,
  output logic          busy,
  output logic          done,
  output logic          aborted
);

  state_t        state;
  logic [LW-1:0] remaining;
  logic [W-1:0]  next_count;
  logic          tbl_we;

  assign cfg_ready = (state == IDLE);
  assign busy      = (state == RUN) || (state == PAUSE);
  assign tbl_we    = cfg_valid && cfg_ready;

  lut_seq_table #(.W(W)) u_table (
    .clk   (clk),
    .reset (reset),
    .we    (tbl_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (count),
    .rdata (next_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      remaining <= '0;
      step      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      step    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (clr) begin
            count <= '0;
          end
          if (start) begin
            if (run_len != '0) begin
              remaining <= run_len;
              state     <= RUN;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        // stop outranks pause, which outranks stepping
        RUN: begin
          if (stop) begin
            state   <= IDLE;
            aborted <= 1'b1;
          end else if (pause) begin
            state <= PAUSE;
          end else begin
            count     <= next_count;
            remaining <= remaining - LW'(1);
            step      <= 1'b1;
            if (remaining == LW'(1)) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        PAUSE: begin
          if (stop) begin
            state   <= IDLE;
            aborted <= 1'b1;
          end else if (!pause) begin
            state <= RUN;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
